// File: rtl/video_timing_gen_if.sv
// ---------------------------------------------------------------------------
// video_timing_gen_if
// Configuration handshake bundle for video_timing_gen. The master offers a
// complete raster timing set (cfg_valid plus every field); the slave
// (the timing generator) answers with cfg_ready and a one-cycle cfg_err
// pulse when an accepted offer is illegal.
//   cfg_valid              master -> slave  new timing offered
//   cfg_ready              slave  -> master shadow register free
//   cfg_err                slave  -> master accepted offer was illegal
//   cfg_h_active/fp/sync/bp master -> slave horizontal timing (CW bits)
//   cfg_v_active/fp/sync/bp master -> slave vertical timing (CW bits)
//   cfg_hpol, cfg_vpol     master -> slave  sync polarity, 1 = active-high
// ---------------------------------------------------------------------------
interface video_timing_gen_if #(
    parameter int CW = 12
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic          cfg_err;
    logic [CW-1:0] cfg_h_active;
    logic [CW-1:0] cfg_h_fp;
    logic [CW-1:0] cfg_h_sync;
    logic [CW-1:0] cfg_h_bp;
    logic [CW-1:0] cfg_v_active;
    logic [CW-1:0] cfg_v_fp;
    logic [CW-1:0] cfg_v_sync;
    logic [CW-1:0] cfg_v_bp;
    logic          cfg_hpol;
    logic          cfg_vpol;

    modport master (
        output cfg_valid, cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
               cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_hpol, cfg_vpol,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
               cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_hpol, cfg_vpol,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
// Run-time programmable raster timing generator. Counts hcount/vcount over a
// live timing set, decodes sync/de/frame_start/line_start one clock after the
// counters, and delays those decoded strobes by OUT_DELAY further stages to
// line up with downstream pixel latency. New timing arrives through a shadow
// register and only becomes live on a frame boundary (or at once when idle),
// so no frame ever mixes two timings.
// Ports:
//   clk          pixel clock
//   reset_n      asynchronous active-low reset
//   enable       1 = generate raster, 0 = finish current frame then idle
//   cfg          configuration handshake (video_timing_gen_if.slave)
//   hcount/vcount raw raster position (undelayed)
//   hsync/vsync  polarity-applied syncs, delayed OUT_DELAY
//   de           active-area enable, delayed OUT_DELAY
//   frame_start  pulse at (0,0), delayed OUT_DELAY
//   line_start   pulse at hcount==0, delayed OUT_DELAY
//   frame_count  frames begun since reset (wraps)
//   running      1 while in RUN or DRAIN
// ---------------------------------------------------------------------------
module video_timing_gen #(
    parameter int          CW           = 12,
    parameter int          FC_W         = 16,
    parameter int          OUT_DELAY    = 0,
    parameter int unsigned DEF_H_ACTIVE = 32'd1280,
    parameter int unsigned DEF_H_FP     = 32'd110,
    parameter int unsigned DEF_H_SYNC   = 32'd40,
    parameter int unsigned DEF_H_BP     = 32'd220,
    parameter int unsigned DEF_V_ACTIVE = 32'd720,
    parameter int unsigned DEF_V_FP     = 32'd5,
    parameter int unsigned DEF_V_SYNC   = 32'd5,
    parameter int unsigned DEF_V_BP     = 32'd20,
    parameter logic        DEF_HPOL     = 1'b1,
    parameter logic        DEF_VPOL     = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    video_timing_gen_if.slave cfg,
    output logic [CW-1:0]     hcount,
    output logic [CW-1:0]     vcount,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              frame_start,
    output logic              line_start,
    output logic [FC_W-1:0]   frame_count,
    output logic              running
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [CW-1:0] h_act;
        logic [CW-1:0] h_fp;
        logic [CW-1:0] h_sync;
        logic [CW-1:0] h_bp;
        logic [CW-1:0] v_act;
        logic [CW-1:0] v_fp;
        logic [CW-1:0] v_sync;
        logic [CW-1:0] v_bp;
        logic          hpol;
        logic          vpol;
    } timing_t;

    localparam timing_t DEF_TIMING = '{
        h_act:  CW'(DEF_H_ACTIVE), h_fp: CW'(DEF_H_FP),
        h_sync: CW'(DEF_H_SYNC),   h_bp: CW'(DEF_H_BP),
        v_act:  CW'(DEF_V_ACTIVE), v_fp: CW'(DEF_V_FP),
        v_sync: CW'(DEF_V_SYNC),   v_bp: CW'(DEF_V_BP),
        hpol:   DEF_HPOL,          vpol: DEF_VPOL
    };

    localparam logic [CW-1:0]   ONE_CW  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [FC_W-1:0] ONE_FC  = {{(FC_W-1){1'b0}}, 1'b1};
    localparam logic [CW+1:0]   ONE_T   = {{(CW+1){1'b0}}, 1'b1};
    // Largest legal total: exactly 2^CW, so the last count still fits CW bits.
    localparam logic [CW+1:0]   TOT_MAX = {2'b01, {CW{1'b0}}};
    // Pipe word layout: {frame_start, line_start, de, vsync, hsync}.
    localparam logic [4:0]      PIPE_RST = {1'b0, 1'b0, 1'b0, ~DEF_VPOL, ~DEF_HPOL};

    // Sum of four timing fields, widened so no combination can overflow.
    function automatic logic [CW+1:0] tot_f(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                            input logic [CW-1:0] c, input logic [CW-1:0] d);
        tot_f = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    endfunction

    state_e          state_q, state_d;
    logic [CW-1:0]   h_q, h_d, v_q, v_d;
    logic [FC_W-1:0] fc_q, fc_d;
    timing_t         live_q, live_d, shadow_q, shadow_d;
    logic            pending_q, pending_d;
    logic            err_q, err_d;
    logic [4:0]      pipe_q [0:OUT_DELAY];

    timing_t         cfg_in_s;
    logic [CW+1:0]   h_tot_s, v_tot_s, cfg_h_tot_s, cfg_v_tot_s;
    logic            run_s, h_last_s, v_last_s, frame_wrap_s;
    logic            xfer_s, cfg_legal_s;
    logic [CW+1:0]   h_ext_s, v_ext_s, hs_lo_s, hs_hi_s, vs_lo_s, vs_hi_s;
    logic            hs_raw_s, vs_raw_s;
    logic [4:0]      dec_s;

    assign cfg_in_s = '{
        h_act:  cfg.cfg_h_active, h_fp: cfg.cfg_h_fp,
        h_sync: cfg.cfg_h_sync,   h_bp: cfg.cfg_h_bp,
        v_act:  cfg.cfg_v_active, v_fp: cfg.cfg_v_fp,
        v_sync: cfg.cfg_v_sync,   v_bp: cfg.cfg_v_bp,
        hpol:   cfg.cfg_hpol,     vpol: cfg.cfg_vpol
    };

    assign h_tot_s      = tot_f(live_q.h_act, live_q.h_fp, live_q.h_sync, live_q.h_bp);
    assign v_tot_s      = tot_f(live_q.v_act, live_q.v_fp, live_q.v_sync, live_q.v_bp);
    assign cfg_h_tot_s  = tot_f(cfg_in_s.h_act, cfg_in_s.h_fp, cfg_in_s.h_sync, cfg_in_s.h_bp);
    assign cfg_v_tot_s  = tot_f(cfg_in_s.v_act, cfg_in_s.v_fp, cfg_in_s.v_sync, cfg_in_s.v_bp);

    assign run_s        = (state_q != ST_IDLE);
    assign h_last_s     = ({2'b00, h_q} == (h_tot_s - ONE_T));
    assign v_last_s     = ({2'b00, v_q} == (v_tot_s - ONE_T));
    assign frame_wrap_s = run_s && h_last_s && v_last_s;

    // cfg_ready is simply "no pending shadow", so a transfer can never
    // coincide with the apply edge.
    assign xfer_s       = cfg.cfg_valid && !pending_q;
    assign cfg_legal_s  = (cfg_in_s.h_act  != {CW{1'b0}}) && (cfg_in_s.h_sync != {CW{1'b0}}) &&
                          (cfg_in_s.v_act  != {CW{1'b0}}) && (cfg_in_s.v_sync != {CW{1'b0}}) &&
                          (cfg_h_tot_s <= TOT_MAX) && (cfg_v_tot_s <= TOT_MAX);

    // Next-state logic of the IDLE/RUN/DRAIN controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_RUN;
                else        state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (!enable) state_d = ST_DRAIN;
                else         state_d = ST_RUN;
            end
            ST_DRAIN: begin
                if (frame_wrap_s) state_d = enable ? ST_RUN : ST_IDLE;
                else              state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Raster counters and frame counter next values.
    always_comb begin
        h_d  = h_q;
        v_d  = v_q;
        fc_d = fc_q;
        if (run_s) begin
            if (h_last_s) begin
                h_d = {CW{1'b0}};
                if (v_last_s) v_d = {CW{1'b0}};
                else          v_d = v_q + ONE_CW;
            end else begin
                h_d = h_q + ONE_CW;
            end
        end else begin
            h_d = {CW{1'b0}};
            v_d = {CW{1'b0}};
        end
        // A frame begins when leaving IDLE or when a wrap continues in RUN;
        // a wrap that drops back to IDLE starts nothing.
        if ((state_q == ST_IDLE && enable) || (frame_wrap_s && state_d == ST_RUN)) begin
            fc_d = fc_q + ONE_FC;
        end else begin
            fc_d = fc_q;
        end
    end

    // Shadow/live timing handoff and illegal-config flag.
    always_comb begin
        live_d    = live_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        err_d     = 1'b0;
        if (pending_q && (frame_wrap_s || state_q == ST_IDLE)) begin
            live_d    = shadow_q;
            pending_d = 1'b0;
        end else if (xfer_s) begin
            if (cfg_legal_s) begin
                shadow_d  = cfg_in_s;
                pending_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            pending_d = pending_q;
        end
    end

    assign h_ext_s  = {2'b00, h_q};
    assign v_ext_s  = {2'b00, v_q};
    assign hs_lo_s  = {2'b00, live_q.h_act} + {2'b00, live_q.h_fp};
    assign hs_hi_s  = hs_lo_s + {2'b00, live_q.h_sync};
    assign vs_lo_s  = {2'b00, live_q.v_act} + {2'b00, live_q.v_fp};
    assign vs_hi_s  = vs_lo_s + {2'b00, live_q.v_sync};
    assign hs_raw_s = (h_ext_s >= hs_lo_s) && (h_ext_s < hs_hi_s);
    assign vs_raw_s = (v_ext_s >= vs_lo_s) && (v_ext_s < vs_hi_s);

    // Raw strobe decode of the current position; idle forces inactive levels
    // because the parked (0,0) position would otherwise decode as active.
    always_comb begin
        dec_s = {1'b0, 1'b0, 1'b0, ~live_q.vpol, ~live_q.hpol};
        if (run_s) begin
            dec_s = {(h_q == {CW{1'b0}}) && (v_q == {CW{1'b0}}),
                     (h_q == {CW{1'b0}}),
                     (h_ext_s < {2'b00, live_q.h_act}) && (v_ext_s < {2'b00, live_q.v_act}),
                     vs_raw_s ^ ~live_q.vpol,
                     hs_raw_s ^ ~live_q.hpol};
        end else begin
            dec_s = {1'b0, 1'b0, 1'b0, ~live_q.vpol, ~live_q.hpol};
        end
    end

    // Control, counter and configuration registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            h_q       <= {CW{1'b0}};
            v_q       <= {CW{1'b0}};
            fc_q      <= {FC_W{1'b0}};
            live_q    <= DEF_TIMING;
            shadow_q  <= DEF_TIMING;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            v_q       <= v_d;
            fc_q      <= fc_d;
            live_q    <= live_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    // Decode register followed by OUT_DELAY alignment stages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= OUT_DELAY; i++) begin
                pipe_q[i] <= PIPE_RST;
            end
        end else begin
            pipe_q[0] <= dec_s;
            for (int i = 1; i <= OUT_DELAY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign hcount        = h_q;
    assign vcount        = v_q;
    assign frame_count   = fc_q;
    assign running       = run_s;
    assign cfg.cfg_ready = ~pending_q;
    assign cfg.cfg_err   = err_q;
    assign hsync         = pipe_q[OUT_DELAY][0];
    assign vsync         = pipe_q[OUT_DELAY][1];
    assign de            = pipe_q[OUT_DELAY][2];
    assign line_start    = pipe_q[OUT_DELAY][3];
    assign frame_start   = pipe_q[OUT_DELAY][4];

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
// Directed bench for video_timing_gen (OUT_DELAY = 3). A behavioural
// reference model advances once per clock from the driven inputs and pushes
// the expected observable word into a queue; the word is popped and compared
// with the DUT on the following falling edge. A few constant checks pin down
// reset values, handshake levels and the restart latency.
// Observable word: {hcount, vcount, frame_count, running, cfg_ready, cfg_err,
//                   hsync, vsync, de, frame_start, line_start}
// ---------------------------------------------------------------------------
module tb_video_timing_gen;
    localparam int CW   = 12;
    localparam int FC_W = 16;
    localparam int OD   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    logic            enable;
    logic [CW-1:0]   hcount, vcount;
    logic            hsync, vsync, de, frame_start, line_start, running;
    logic [FC_W-1:0] frame_count;

    video_timing_gen_if #(.CW(CW)) cfg_if ();

    video_timing_gen #(.CW(CW), .FC_W(FC_W), .OUT_DELAY(OD)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .cfg         (cfg_if.slave),
        .hcount      (hcount),
        .vcount      (vcount),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .frame_start (frame_start),
        .line_start  (line_start),
        .frame_count (frame_count),
        .running     (running)
    );

    localparam logic [47:0] RST_WORD = {12'd0, 12'd0, 16'd0, 1'b0, 1'b1, 1'b0, 5'b00000};

    int n_total = 0;
    int n_bad   = 0;
    logic [47:0] exp_q [$];

    // ---------------- reference model state ----------------
    int   m_st;              // 0 idle, 1 run, 2 drain
    int   m_h, m_v, m_fc;
    int   lv [8];            // live: h act/fp/sync/bp, v act/fp/sync/bp
    int   sh [8];
    bit   lhp, lvp, shp, svp;
    bit   m_pend, m_err;
    logic [4:0] m_dly [4];   // {fs, ls, de, vs, hs}, index 3 is visible

    function automatic logic [47:0] obs_word();
        return {hcount, vcount, frame_count, running, cfg_if.cfg_ready, cfg_if.cfg_err,
                hsync, vsync, de, frame_start, line_start};
    endfunction

    function automatic logic [47:0] exp_word();
        logic [4:0] d;
        d = m_dly[3];
        return {m_h[11:0], m_v[11:0], m_fc[15:0], (m_st != 0), !m_pend, m_err,
                d[0], d[1], d[2], d[4], d[3]};
    endfunction

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_h = 0; m_v = 0; m_fc = 0;
        lv = '{1280, 110, 40, 220, 720, 5, 5, 20};
        sh = lv;
        lhp = 1'b1; lvp = 1'b1; shp = 1'b1; svp = 1'b1;
        m_pend = 1'b0; m_err = 1'b0;
        for (int i = 0; i < 4; i++) m_dly[i] = 5'b00000;
    endtask

    task automatic model_step();
        int  htot, vtot, nst;
        bit  run, hlast, vlast, fw, hsr, vsr, xfer, legal;
        int  c [8];
        logic [4:0] dec;
        htot  = lv[0] + lv[1] + lv[2] + lv[3];
        vtot  = lv[4] + lv[5] + lv[6] + lv[7];
        run   = (m_st != 0);
        hlast = (m_h == htot - 1);
        vlast = (m_v == vtot - 1);
        fw    = run && hlast && vlast;
        hsr   = (m_h >= lv[0] + lv[1]) && (m_h < lv[0] + lv[1] + lv[2]);
        vsr   = (m_v >= lv[4] + lv[5]) && (m_v < lv[4] + lv[5] + lv[6]);
        dec[0] = run ? (hsr ? lhp : !lhp) : !lhp;
        dec[1] = run ? (vsr ? lvp : !lvp) : !lvp;
        dec[2] = run && (m_h < lv[0]) && (m_v < lv[4]);
        dec[3] = run && (m_h == 0);
        dec[4] = run && (m_h == 0) && (m_v == 0);
        case (m_st)
            0:       nst = enable ? 1 : 0;
            1:       nst = enable ? 1 : 2;
            default: nst = fw ? (enable ? 1 : 0) : 2;
        endcase
        if ((m_st == 0 && enable) || (fw && nst == 1)) m_fc = (m_fc + 1) % 65536;
        if (run) begin
            if (hlast) begin
                m_h = 0;
                m_v = vlast ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end
        c = '{int'(cfg_if.cfg_h_active), int'(cfg_if.cfg_h_fp), int'(cfg_if.cfg_h_sync),
              int'(cfg_if.cfg_h_bp), int'(cfg_if.cfg_v_active), int'(cfg_if.cfg_v_fp),
              int'(cfg_if.cfg_v_sync), int'(cfg_if.cfg_v_bp)};
        xfer  = cfg_if.cfg_valid && !m_pend;
        legal = (c[0] != 0) && (c[2] != 0) && (c[4] != 0) && (c[6] != 0) &&
                (c[0] + c[1] + c[2] + c[3] <= 4096) && (c[4] + c[5] + c[6] + c[7] <= 4096);
        m_err = 1'b0;
        if (m_pend && (fw || m_st == 0)) begin
            lv = sh; lhp = shp; lvp = svp; m_pend = 1'b0;
        end else if (xfer) begin
            if (legal) begin
                sh = c; shp = cfg_if.cfg_hpol; svp = cfg_if.cfg_vpol; m_pend = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
        m_dly[3] = m_dly[2];
        m_dly[2] = m_dly[1];
        m_dly[1] = m_dly[0];
        m_dly[0] = dec;
        m_st = nst;
    endtask

    // One clock per iteration: model advances at the edge, DUT is compared
    // on the falling edge. Returns at the falling edge so inputs change there.
    task automatic step(input string tag, input int n);
        logic [47:0] e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            exp_q.push_back(exp_word());
            @(negedge clk);
            e = exp_q.pop_front();
            check(tag, obs_word(), e);
        end
    endtask

    task automatic set_cfg(input int ha, input int hf, input int hs, input int hb,
                           input int va, input int vf, input int vs, input int vb,
                           input bit hp, input bit vp);
        cfg_if.cfg_h_active = CW'(ha); cfg_if.cfg_h_fp = CW'(hf);
        cfg_if.cfg_h_sync   = CW'(hs); cfg_if.cfg_h_bp = CW'(hb);
        cfg_if.cfg_v_active = CW'(va); cfg_if.cfg_v_fp = CW'(vf);
        cfg_if.cfg_v_sync   = CW'(vs); cfg_if.cfg_v_bp = CW'(vb);
        cfg_if.cfg_hpol     = hp;      cfg_if.cfg_vpol = vp;
    endtask

    initial begin
        // Reset with the raster disabled.
        reset_n = 1'b0;
        enable  = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
        model_reset();
        #1;
        check("reset_state", obs_word(), RST_WORD);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        step("idle", 2);

        // Small timing loaded while idle: applies the cycle after transfer.
        set_cfg(8, 2, 2, 4, 4, 1, 1, 2, 1'b1, 1'b1);
        cfg_if.cfg_valid = 1'b1;
        step("cfg_small_xfer", 1);
        cfg_if.cfg_valid = 1'b0;
        check("ready_low_pending", {47'd0, cfg_if.cfg_ready}, 48'd0);
        step("cfg_small_apply", 1);
        check("ready_high_applied", {47'd0, cfg_if.cfg_ready}, 48'd1);

        // Two-plus frames of 16x8 raster.
        enable = 1'b1;
        step("run_small", 300);
        check("fc_after_small", {32'd0, frame_count}, 48'd3);

        // Same timing with inverted hsync, offered mid-frame.
        set_cfg(8, 2, 2, 4, 4, 1, 1, 2, 1'b0, 1'b1);
        cfg_if.cfg_valid = 1'b1;
        step("cfg_hpol0_xfer", 1);
        cfg_if.cfg_valid = 1'b0;
        step("run_hpol0", 260);

        // Narrower line offered mid-frame, valid held across several cycles.
        set_cfg(6, 1, 1, 2, 4, 1, 1, 2, 1'b1, 1'b1);
        cfg_if.cfg_valid = 1'b1;
        step("cfg_h10_hold", 3);
        cfg_if.cfg_valid = 1'b0;
        step("run_h10", 300);

        // Illegal offers: zero sync width, then a line longer than 2^CW.
        set_cfg(8, 2, 0, 4, 4, 1, 1, 2, 1'b1, 1'b1);
        cfg_if.cfg_valid = 1'b1;
        step("cfg_bad_sync", 1);
        cfg_if.cfg_valid = 1'b0;
        check("err_pulse_sync", {46'd0, cfg_if.cfg_err, cfg_if.cfg_ready}, 48'd3);
        step("after_bad_sync", 1);
        check("err_clears", {47'd0, cfg_if.cfg_err}, 48'd0);
        set_cfg(4000, 94, 1, 2, 4, 1, 1, 2, 1'b1, 1'b1);
        cfg_if.cfg_valid = 1'b1;
        step("cfg_bad_htot", 1);
        cfg_if.cfg_valid = 1'b0;
        check("err_pulse_htot", {47'd0, cfg_if.cfg_err}, 48'd1);
        step("run_after_err", 40);

        // Drop enable on line 2, let the frame drain to idle, then restart.
        for (int k = 0; k < 200; k++) begin
            if (m_v != 2) step("align_v2", 1);
        end
        check("aligned_v2", {36'd0, vcount}, 48'd2);
        enable = 1'b0;
        step("drain", 100);
        check("idle_after_drain", {43'd0, running, hsync, vsync, de, frame_start}, 48'd0);
        enable = 1'b1;
        step("restart_enter", 1);
        step("restart_wait", OD);
        check("restart_fs_early", {47'd0, frame_start}, 48'd0);
        step("restart_fs", 1);
        check("restart_fs_on", {47'd0, frame_start}, 48'd1);

        // Pending config, then asynchronous reset mid-line.
        set_cfg(8, 2, 2, 4, 4, 1, 1, 2, 1'b0, 1'b0);
        cfg_if.cfg_valid = 1'b1;
        step("cfg_before_reset", 1);
        cfg_if.cfg_valid = 1'b0;
        step("pending_run", 3);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", obs_word(), RST_WORD);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        check("reset_held", obs_word(), RST_WORD);
        reset_n = 1'b1;

        // Default 1650-pixel line is live again after reset.
        step("default_timing", 1700);
        check("default_line_wrap", {36'd0, vcount}, 48'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
